// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider producing one quotient bit per clock.
// quotient = dividend / divisor, remainder = dividend % divisor.
// A start/done handshake lets the control FSM launch an operation and pick
// up the result; results and div_zero are held until the next completion.
//
// Parameters:
//   Size       operand, quotient and remainder width in bits (>= 2)
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start      request, only sampled while idle
//   dividend   numerator, captured when start is accepted
//   divisor    denominator, captured when start is accepted
//   busy       high while calculating and during the done cycle
//   done       one-cycle pulse, results valid from this cycle on
//   quotient   result quotient (all ones on divide-by-zero)
//   remainder  result remainder (dividend on divide-by-zero)
//   div_zero   divisor was zero for the last completed operation
//
// Configuration macro:
//   DIV_SIGNED_EN  when defined, operands are two's complement; magnitudes
//                  are divided and the signs are applied when the result is
//                  loaded. Undefined: plain unsigned divider.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [Size-1:0] dividend,
    input  logic [Size-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [Size-1:0] quotient,
    output logic [Size-1:0] remainder,
    output logic            div_zero
);

    localparam int CntW = $clog2(Size + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CntW-1:0]   count_q,     count_d;
    logic [Size-1:0]   part_rem_q,  part_rem_d;
    logic [Size-1:0]   work_q,      work_d;
    logic [Size-1:0]   dsr_q,       dsr_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [Size-1:0]   quotient_q,  quotient_d;
    logic [Size-1:0]   remainder_q, remainder_d;
    logic              div_zero_q,  div_zero_d;
`ifdef DIV_SIGNED_EN
    logic              neg_quo_q,   neg_quo_d;
    logic              neg_rem_q,   neg_rem_d;
`endif

    logic [Size:0]     shifted;
    logic [Size:0]     trial;
    logic              no_borrow;
    logic [Size-1:0]   step_rem;
    logic [Size-1:0]   step_quo;
    logic [Size-1:0]   fin_quo;
    logic [Size-1:0]   fin_rem;
    logic [Size-1:0]   dvd_mag;
    logic [Size-1:0]   dsr_mag;

    always_comb begin
        // Trial subtraction of the shifted partial remainder (Size+1 bits)
        // against the divisor: adder in subtract mode, inverted divisor with
        // carry-in 1. The low Size bits go through the adder; a set top bit
        // of the shifted value already guarantees the divisor fits, so the
        // low-bit difference is then exact as well.
        shifted   = {part_rem_q, work_q[Size-1]};
        trial     = {1'b0, shifted[Size-1:0]} + {1'b0, ~dsr_q} + {{Size{1'b0}}, 1'b1};
        no_borrow = shifted[Size] | trial[Size];
        step_rem  = no_borrow ? trial[Size-1:0] : shifted[Size-1:0];
        step_quo  = {work_q[Size-2:0], no_borrow};

`ifdef DIV_SIGNED_EN
        // Divide magnitudes; the most-negative value maps onto itself, which
        // reads correctly as an unsigned magnitude.
        dvd_mag = dividend[Size-1] ? -dividend : dividend;
        dsr_mag = divisor[Size-1]  ? -divisor  : divisor;
        fin_quo = neg_quo_q ? -step_quo : step_quo;
        fin_rem = neg_rem_q ? -step_rem : step_rem;
`else
        dvd_mag = dividend;
        dsr_mag = divisor;
        fin_quo = step_quo;
        fin_rem = step_rem;
`endif
    end

    // Next-state and next-output logic. All outputs come from flops, so the
    // done/busy/result values are set up here one edge ahead.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        part_rem_d  = part_rem_q;
        work_d      = work_q;
        dsr_d       = dsr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        // Divide-by-zero completes straight away with the
                        // fixed result pattern.
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d    = CALC;
                        count_d    = CntW'(Size);
                        part_rem_d = '0;
                        work_d     = dvd_mag;
                        dsr_d      = dsr_mag;
`ifdef DIV_SIGNED_EN
                        neg_quo_d  = dividend[Size-1] ^ divisor[Size-1];
                        neg_rem_d  = dividend[Size-1];
`endif
                    end
                end
            end

            CALC: begin
                part_rem_d = step_rem;
                work_d     = step_quo;
                count_d    = count_q - CntW'(1);
                // The last step lands its result directly in the output
                // registers so done and the results appear together.
                if (count_q == CntW'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
                    div_zero_d  = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single state register for the FSM and all of its registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            part_rem_q  <= '0;
            work_q      <= '0;
            dsr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            part_rem_q  <= part_rem_d;
            work_q      <= work_d;
            dsr_q       <= dsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (Size = 8). A behavioural model
// tracks when each accepted operation must finish and what it must return
// (plain / and % arithmetic); a compare process checks busy, done and the
// held results against it on every cycle. Directed cases pin the model with
// hand-computed values, then randomized operations follow.
// Honours DIV_SIGNED_EN for the reference arithmetic and the signed cases.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int SIZE = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;
    int lat;

    seq_divider #(.Size(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference result as {div_zero, quotient, remainder}.
    function automatic logic [16:0] model_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        logic [7:0] r;
        int sa;
        int sb;
        if (b == 8'd0) begin
            return {1'b1, 8'hFF, a};
        end
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = 8'(sa / sb);
        r  = 8'(sa % sb);
`else
        sa = 0;
        sb = 0;
        q  = a / b;
        r  = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an accepted start finishes SIZE edges later (divisor != 0) or
    // on the accepting edge itself (divisor == 0); busy drops one cycle
    // after done; reset cancels everything.
    logic        exp_busy;
    logic        exp_done;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    logic        exp_dz;
    logic        in_flight;
    int          edges_left;
    logic [16:0] pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_busy   <= 1'b0;
            exp_done   <= 1'b0;
            exp_q      <= 8'd0;
            exp_r      <= 8'd0;
            exp_dz     <= 1'b0;
            in_flight  <= 1'b0;
            edges_left <= 0;
        end else if (exp_done) begin
            exp_done <= 1'b0;
            exp_busy <= 1'b0;
        end else if (in_flight) begin
            if (edges_left == 1) begin
                in_flight <= 1'b0;
                exp_done  <= 1'b1;
                {exp_dz, exp_q, exp_r} <= pend;
            end
            edges_left <= edges_left - 1;
        end else if (start) begin
            exp_busy <= 1'b1;
            if (divisor == 8'd0) begin
                exp_done <= 1'b1;
                {exp_dz, exp_q, exp_r} <= model_div(dividend, divisor);
            end else begin
                in_flight  <= 1'b1;
                edges_left <= SIZE;
                pend       <= model_div(dividend, divisor);
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            if (!exp_busy || exp_done) begin
                checkOutput("quotient", 32'(quotient), 32'(exp_q));
                checkOutput("remainder", 32'(remainder), 32'(exp_r));
                checkOutput("div_zero", 32'(div_zero), 32'(exp_dz));
            end
        end
    end

    // Waits for idle, pulses start for one cycle and returns the cycle
    // number (1 = first cycle after the accepting edge) in which done rose.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int cyc);
        int w;
        w = 0;
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1;
        int t2;
        int dones;
        int hold;
        int w;
        int sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1
        applyStimulus(8'd100, 8'd7, lat);
        checkOutput("t1_latency", 32'(lat), 32'd9);
        checkOutput("t1_quotient", 32'(quotient), 32'd14);
        checkOutput("t1_remainder", 32'(remainder), 32'd2);
        checkOutput("t1_div_zero", 32'(div_zero), 32'd0);

        // T2
        applyStimulus(8'd255, 8'd1, lat);
        checkOutput("t2a_quotient", 32'(quotient), 32'd255);
        checkOutput("t2a_remainder", 32'(remainder), 32'd0);
        applyStimulus(8'd3, 8'd200, lat);
        checkOutput("t2b_quotient", 32'(quotient), 32'd0);
        checkOutput("t2b_remainder", 32'(remainder), 32'd3);

        // T3
        applyStimulus(8'd5, 8'd0, lat);
        checkOutput("t3_latency", 32'(lat), 32'd1);
        checkOutput("t3_quotient", 32'(quotient), 32'hFF);
        checkOutput("t3_remainder", 32'(remainder), 32'd5);
        checkOutput("t3_div_zero", 32'(div_zero), 32'd1);
        applyStimulus(8'd9, 8'd3, lat);
        checkOutput("t3b_div_zero", 32'(div_zero), 32'd0);
        checkOutput("t3b_quotient", 32'(quotient), 32'd3);

        // T4: second start during CALC is ignored
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                dones++;
                checkOutput("t4_quotient", 32'(quotient), 32'd14);
                checkOutput("t4_remainder", 32'(remainder), 32'd2);
            end
            @(negedge clk);
        end
        checkOutput("t4_done_count", 32'(dones), 32'd1);

        // T5: reset in cycle 5 of an operation
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_quotient", 32'(quotient), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checkOutput("t5_done_count", 32'(dones), 32'd0);
        applyStimulus(8'd20, 8'd6, lat);
        checkOutput("t5_quotient2", 32'(quotient), 32'd3);
        checkOutput("t5_remainder2", 32'(remainder), 32'd2);

`ifdef DIV_SIGNED_EN
        // T6
        applyStimulus(8'h9C, 8'd7, lat);
        checkOutput("t6_latency", 32'(lat), 32'd9);
        checkOutput("t6a_quotient", 32'(quotient), 32'hF2);
        checkOutput("t6a_remainder", 32'(remainder), 32'hFE);
        applyStimulus(8'h80, 8'hFF, lat);
        checkOutput("t6b_quotient", 32'(quotient), 32'h80);
        checkOutput("t6b_remainder", 32'(remainder), 32'h00);
        checkOutput("t6b_div_zero", 32'(div_zero), 32'd0);
`endif

        // Back-to-back: start held high gives one operation per SIZE+2 cycles
        w = 0;
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        start = 1'b0;
        checkOutput("b2b_period", 32'(t2 - t1), 32'(SIZE + 2));

        // Randomized operations, with start held over busy periods, operand
        // noise while busy, and occasional mid-operation resets.
        for (int n = 0; n < 250; n++) begin
            @(negedge clk);
            dividend = 8'($urandom);
            sel = $urandom_range(0, 11);
            if (sel == 0) divisor = 8'd0;
            else if (sel < 4) divisor = 8'($urandom_range(1, 15));
            else if (sel == 4) begin
                dividend = 8'h80;
                divisor  = 8'hFF;
            end else divisor = 8'($urandom);
            start = 1'b1;
            hold  = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (h < hold - 1) begin
                    dividend = 8'($urandom);
                    divisor  = 8'($urandom);
                end
            end
            start    = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            w = 0;
            while (busy && w < 40) begin
                @(negedge clk);
                w++;
            end
            checkOutput("random_idle", 32'(busy), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
